// File: rtl/gmii_rx_stream.sv
// GMII receive parser: filters frames by MAC, EtherType and stream id, then
// unpacks 48-bit video words or 12-bit audio samples into the downstream FIFOs.
module gmii_rx_stream #(
  parameter logic [47:0] MAC_ADDR  = 48'h00_37_FF_00_00_01,
  parameter logic [15:0] ETHTYPE   = 16'h88B5,
  parameter int          VID_WORDS = 160,
  parameter int          AUD_MAX   = 10
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vid_full,
  output logic        vid_wr_en,
  output logic [47:0] vid_din,
  output logic [10:0] vid_line,
  input  logic        aud_full,
  output logic        aud_wr_en,
  output logic [11:0] aud_din,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [3:0] {IDLE, PRE, DA, SA, ETYPE, HDR, VDATA, ADATA, DROP} state_t;

  state_t      state;
  logic [3:0]  bcnt;
  logic [15:0] wcnt;
  logic [39:0] sr;
  logic        uc_miss, bc_miss, hdr_bad, is_aud;
  logic [2:0]  line_hi;
  logic [3:0]  aud_n;

  logic [47:0] mac_sh;
  logic [7:0]  da_byte, et_byte;
  logic        uc_next, bc_next, abort, n_ok, last_vid, last_aud;

  always_comb begin
    mac_sh   = MAC_ADDR << {bcnt, 3'b000};
    da_byte  = mac_sh[47:40];
    et_byte  = bcnt[0] ? ETHTYPE[7:0] : ETHTYPE[15:8];
    uc_next  = uc_miss | (rxd != da_byte);
    bc_next  = bc_miss | (rxd != 8'hFF);
    abort    = !rx_dv | rx_er;
    n_ok     = (rxd[3:0] != 4'd0) && ({28'd0, rxd[3:0]} <= 32'(AUD_MAX));
    last_vid = (wcnt == 16'(VID_WORDS - 1));
    last_aud = (wcnt == {12'd0, aud_n} - 16'd1);
  end

  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      wcnt      <= '0;
      sr        <= '0;
      uc_miss   <= 1'b0;
      bc_miss   <= 1'b0;
      hdr_bad   <= 1'b0;
      is_aud    <= 1'b0;
      line_hi   <= '0;
      aud_n     <= '0;
      vid_wr_en <= 1'b0;
      vid_din   <= '0;
      vid_line  <= '0;
      aud_wr_en <= 1'b0;
      aud_din   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      vid_wr_en <= 1'b0;
      aud_wr_en <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (rx_dv && rxd == 8'h55) state <= PRE;
        PRE: begin
          if (!rx_dv) state <= IDLE;
          else if (rxd == 8'hD5) begin
            state   <= DA;
            bcnt    <= '0;
            uc_miss <= 1'b0;
            bc_miss <= 1'b0;
          end else if (rxd != 8'h55) state <= DROP;
        end
        DA: begin
          if (abort) state <= IDLE;
          else begin
            uc_miss <= uc_next;
            bc_miss <= bc_next;
            bcnt    <= bcnt + 4'd1;
            if (bcnt == 4'd5) begin
              bcnt  <= '0;
              state <= (uc_next && bc_next) ? DROP : SA;
            end
          end
        end
        SA: begin
          if (abort) state <= IDLE;
          else begin
            bcnt <= bcnt + 4'd1;
            if (bcnt == 4'd5) begin
              bcnt  <= '0;
              state <= ETYPE;
            end
          end
        end
        ETYPE: begin
          if (abort) state <= IDLE;
          else if (rxd != et_byte) state <= DROP;
          else if (bcnt == 4'd1) begin
            bcnt    <= '0;
            hdr_bad <= 1'b0;
            state   <= HDR;
          end else bcnt <= 4'd1;
        end
        HDR: begin
          if (abort) state <= IDLE;
          else begin
            bcnt <= bcnt + 4'd1;
            case (bcnt)
              4'd0: if (rxd[0] != id) hdr_bad <= 1'b1;
              4'd1: begin
                if (rxd == 8'h00) is_aud <= 1'b0;
                else if (rxd == 8'h01) is_aud <= 1'b1;
                else hdr_bad <= 1'b1;
              end
              4'd2: line_hi <= rxd[2:0];
              default: begin
                bcnt <= '0;
                wcnt <= '0;
                if (hdr_bad) state <= DROP;
                else if (!is_aud) begin
                  vid_line <= {line_hi, rxd};
                  state    <= VDATA;
                end else if (n_ok) begin
                  aud_n <= rxd[3:0];
                  state <= ADATA;
                end else state <= DROP;
              end
            endcase
          end
        end
        // Partial words simply stay in sr on abort; only completed words are written.
        VDATA: begin
          if (abort) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            sr   <= {sr[31:0], rxd};
            bcnt <= bcnt + 4'd1;
            if (bcnt == 4'd5) begin
              bcnt <= '0;
              wcnt <= wcnt + 16'd1;
              if (vid_full) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
              end else begin
                vid_wr_en <= 1'b1;
                vid_din   <= {sr, rxd};
              end
              if (last_vid) begin
                frame_ok <= 1'b1;
                state    <= DROP;
              end
            end
          end
        end
        ADATA: begin
          if (abort) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            sr   <= {sr[31:0], rxd};
            bcnt <= bcnt + 4'd1;
            if (bcnt == 4'd1) begin
              bcnt <= '0;
              wcnt <= wcnt + 16'd1;
              if (aud_full) begin
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
              end else begin
                aud_wr_en <= 1'b1;
                aud_din   <= {sr[3:0], rxd};
              end
              if (last_aud) begin
                frame_ok <= 1'b1;
                state    <= DROP;
              end
            end
          end
        end
        DROP: if (!rx_dv) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_stream.sv
// Bench for gmii_rx_stream: drives byte-level GMII frames and compares the
// captured FIFO writes and pulses against a frame-level reference model.
module tb_gmii_rx_stream;

  localparam logic [47:0] MAC = 48'h00_37_FF_00_00_01;
  localparam logic [15:0] ETH = 16'h88B5;
  localparam int          VW  = 160;
  localparam int          AM  = 10;

  logic        rx_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        id = 1'b1;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = '0;
  logic        vid_full = 1'b0;
  logic        aud_full = 1'b0;
  logic        vid_wr_en, aud_wr_en, frame_ok, frame_err;
  logic [47:0] vid_din;
  logic [10:0] vid_line;
  logic [11:0] aud_din;
  logic [15:0] drop_cnt;

  gmii_rx_stream #(
    .MAC_ADDR (MAC),
    .ETHTYPE  (ETH),
    .VID_WORDS(VW),
    .AUD_MAX  (AM)
  ) dut (
    .rx_clk   (rx_clk),
    .sys_rst  (sys_rst),
    .id       (id),
    .rx_dv    (rx_dv),
    .rx_er    (rx_er),
    .rxd      (rxd),
    .vid_full (vid_full),
    .vid_wr_en(vid_wr_en),
    .vid_din  (vid_din),
    .vid_line (vid_line),
    .aud_full (aud_full),
    .aud_wr_en(aud_wr_en),
    .aud_din  (aud_din),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .drop_cnt (drop_cnt)
  );

  always #4 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0, n_fail = 0;

  // Observed activity, timestamped with the cycle number.
  logic [47:0] vq[$];
  int          vcq[$];
  logic [11:0] aq[$];
  int          acq[$];
  int          okq[$];
  int          errq[$];

  always @(negedge rx_clk) begin
    if (vid_wr_en) begin vq.push_back(vid_din); vcq.push_back(cyc); end
    if (aud_wr_en) begin aq.push_back(aud_din); acq.push_back(cyc); end
    if (frame_ok)  okq.push_back(cyc);
    if (frame_err) errq.push_back(cyc);
  end

  // Frame descriptor and stimulus record.
  logic [47:0] f_da;
  logic [15:0] f_et, f_cnt;
  logic [7:0]  f_idb, f_typ;
  int          f_cut, f_flo, f_fhi, f_rst, f_abort_cyc;
  logic        f_cut_er;
  logic [7:0]  pay[$];
  int          pay_cyc[$];

  int          exp_drop = 0;
  logic [10:0] exp_line = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] b);
    rx_dv = dv;
    rxd   = b;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic defaults();
    f_da = MAC; f_et = ETH; f_idb = 8'h01; f_typ = 8'h00; f_cnt = '0;
    f_cut = -1; f_cut_er = 1'b0; f_flo = -1; f_fhi = -2; f_rst = -1;
    id = 1'b1;
  endtask

  task automatic gen_pay(input int nb);
    pay.delete();
    repeat (nb) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == 8'h55) b = 8'h56;
      pay.push_back(b);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_vid_wr_en"}, 64'(vid_wr_en), 64'd0);
    chk({tag, "_aud_wr_en"}, 64'(aud_wr_en), 64'd0);
    chk({tag, "_frame_ok"},  64'(frame_ok),  64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_vid_din"},   64'(vid_din),   64'd0);
    chk({tag, "_vid_line"},  64'(vid_line),  64'd0);
    chk({tag, "_aud_din"},   64'(aud_din),   64'd0);
    chk({tag, "_drop_cnt"},  64'(drop_cnt),  64'd0);
  endtask

  task automatic send_frame();
    int pre;
    pre = $urandom_range(1, 7);
    pay_cyc.delete();
    f_abort_cyc = -1;
    repeat (pre) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 6; i++) drive(1'b1, f_da[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom));
    drive(1'b1, f_et[15:8]);
    drive(1'b1, f_et[7:0]);
    drive(1'b1, f_idb);
    drive(1'b1, f_typ);
    drive(1'b1, f_cnt[15:8]);
    drive(1'b1, f_cnt[7:0]);
    for (int i = 0; i < pay.size(); i++) begin
      int w;
      w = (f_typ == 8'h01) ? i / 2 : i / 6;
      if (i == f_cut) begin
        f_abort_cyc = cyc;
        if (f_cut_er) begin
          rx_er = 1'b1;
          drive(1'b1, pay[i]);
          rx_er = 1'b0;
        end
        break;
      end
      vid_full = (w >= f_flo && w <= f_fhi);
      aud_full = vid_full;
      sys_rst  = (i == f_rst);
      pay_cyc.push_back(cyc);
      drive(1'b1, pay[i]);
      if (i == f_rst) begin
        sys_rst = 1'b0;
        @(negedge rx_clk);
        check_zero_outputs("midframe_rst");
      end
    end
    vid_full = 1'b0;
    aud_full = 1'b0;
    if (f_cut < 0) repeat (4) drive(1'b1, 8'($urandom_range(0, 8'h54)));
    drive(1'b0, 8'h00);
    @(negedge rx_clk);
    #1;
  endtask

  // Frame-level reference: which words land, which are lost, and when.
  task automatic check_frame(input string tag);
    logic        video, hdr_ok;
    int          n, bpw, nw, eff, got, last_cyc;
    logic [47:0] ev[$];
    int          ec[$];
    logic        exp_ok, exp_err;
    video  = (f_typ == 8'h00);
    n      = int'(f_cnt[3:0]);
    hdr_ok = (f_da == MAC || f_da == '1) && f_et == ETH && f_idb[0] == id &&
             (video || (f_typ == 8'h01 && n >= 1 && n <= AM));
    bpw = video ? 6 : 2;
    nw  = video ? VW : n;
    eff = (f_rst >= 0) ? f_rst : ((f_cut >= 0) ? f_cut : pay.size());
    got = hdr_ok ? eff / bpw : 0;
    if (got > nw) got = nw;
    for (int w = 0; w < got; w++) begin
      if (w >= f_flo && w <= f_fhi) begin
        if (exp_drop < 65535) exp_drop++;
      end else begin
        logic [47:0] v;
        v = '0;
        if (video) for (int k = 0; k < 6; k++) v = {v[39:0], pay[6*w + k]};
        else v = {36'd0, pay[2*w][3:0], pay[2*w + 1]};
        ev.push_back(v);
        ec.push_back(pay_cyc[bpw*w + bpw - 1] + 1);
      end
    end
    if (hdr_ok && video) exp_line = f_cnt[10:0];
    exp_ok  = hdr_ok && got == nw && f_rst < 0;
    exp_err = hdr_ok && got < nw && f_cut >= 0 && f_rst < 0;
    if (f_rst >= 0) begin
      exp_drop = 0;
      exp_line = '0;
    end

    chk({tag, "_vid_writes"}, 64'(vq.size()), 64'(video ? ev.size() : 0));
    chk({tag, "_aud_writes"}, 64'(aq.size()), 64'(video ? 0 : ev.size()));
    if (video) begin
      for (int i = 0; i < vq.size() && i < ev.size(); i++) begin
        chk($sformatf("%s_vid_din[%0d]", tag, i), 64'(vq[i]), 64'(ev[i]));
        chk($sformatf("%s_vid_cyc[%0d]", tag, i), 64'(vcq[i]), 64'(ec[i]));
      end
    end else begin
      for (int i = 0; i < aq.size() && i < ev.size(); i++) begin
        chk($sformatf("%s_aud_din[%0d]", tag, i), 64'(aq[i]), 64'(ev[i]));
        chk($sformatf("%s_aud_cyc[%0d]", tag, i), 64'(acq[i]), 64'(ec[i]));
      end
    end
    chk({tag, "_frame_ok_cnt"}, 64'(okq.size()), 64'(exp_ok));
    if (exp_ok && okq.size() == 1) begin
      last_cyc = pay_cyc[nw*bpw - 1] + 1;
      chk({tag, "_frame_ok_cyc"}, 64'(okq[0]), 64'(last_cyc));
    end
    chk({tag, "_frame_err_cnt"}, 64'(errq.size()), 64'(exp_err));
    if (exp_err && errq.size() == 1)
      chk({tag, "_frame_err_cyc"}, 64'(errq[0]), 64'(f_abort_cyc + 1));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
    chk({tag, "_vid_line"}, 64'(vid_line), 64'(exp_line));
    vq.delete(); vcq.delete(); aq.delete(); acq.delete(); okq.delete(); errq.delete();
  endtask

  initial begin
    sys_rst = 1'b1;
    repeat (3) drive(1'b0, 8'h00);
    @(negedge rx_clk);
    check_zero_outputs("reset");
    sys_rst = 1'b0;
    drive(1'b0, 8'h00);

    // Video frame with sequential word values, line 0x015.
    defaults();
    f_cnt = 16'h0015;
    pay.delete();
    for (int w = 0; w < VW; w++) begin
      logic [47:0] v;
      v = 48'(w);
      for (int k = 0; k < 6; k++) pay.push_back(v[47 - 8*k -: 8]);
    end
    send_frame();
    check_frame("video_seq");

    // Audio frame, ten samples 0xA00..0xA09 with upper nibble 0xF.
    defaults();
    f_typ = 8'h01;
    f_cnt = 16'h000A;
    pay.delete();
    for (int i = 0; i < 10; i++) begin
      pay.push_back(8'hFA);
      pay.push_back(8'(i));
    end
    send_frame();
    check_frame("audio_seq");

    // Filtered frames: wrong DA, wrong EtherType, wrong id, audio n=11, audio n=0.
    defaults(); f_da = 48'h00_37_FF_00_00_02; gen_pay(60); send_frame(); check_frame("flt_da");
    defaults(); f_et = 16'h0800; gen_pay(60); send_frame(); check_frame("flt_etype");
    defaults(); f_idb = 8'h00; gen_pay(60); send_frame(); check_frame("flt_id");
    defaults(); f_typ = 8'h01; f_cnt = 16'h000B; gen_pay(22); send_frame(); check_frame("flt_n11");
    defaults(); f_typ = 8'h01; f_cnt = 16'h0000; gen_pay(22); send_frame(); check_frame("flt_n0");
    defaults(); f_typ = 8'h02; gen_pay(60); send_frame(); check_frame("flt_type");

    // Truncation after 3.5 video words, then a complete frame.
    defaults(); f_cnt = 16'h0123; gen_pay(VW*6); f_cut = 21; send_frame(); check_frame("trunc");
    defaults(); f_cnt = 16'h0042; gen_pay(VW*6); send_frame(); check_frame("after_trunc");

    // rx_er abort inside audio payload.
    defaults(); f_typ = 8'h01; f_cnt = 16'h0008; gen_pay(16); f_cut = 9; f_cut_er = 1'b1;
    send_frame(); check_frame("aud_rx_er");

    // FIFO full across video words 10..14.
    defaults(); f_cnt = 16'h07FF; gen_pay(VW*6); f_flo = 10; f_fhi = 14; send_frame(); check_frame("vid_full");

    // Audio with the final sample dropped: frame_ok must still pulse.
    defaults(); f_typ = 8'h01; f_cnt = 16'hF005; gen_pay(10); f_flo = 4; f_fhi = 4;
    send_frame(); check_frame("aud_full_last");

    // Synchronous reset mid-word in VDATA, then a normal frame.
    defaults(); f_cnt = 16'h0333; gen_pay(VW*6); f_rst = 6*20 + 3; send_frame(); check_frame("rst_mid");
    defaults(); f_cnt = 16'h0100; gen_pay(VW*6); send_frame(); check_frame("after_rst");

    // Randomized frames.
    for (int r = 0; r < 8; r++) begin
      defaults();
      f_typ = 8'($urandom_range(0, 1));
      id    = 1'($urandom);
      f_idb = {7'($urandom), ($urandom_range(0, 3) == 0) ? ~id : id};
      f_da  = $urandom_range(0, 1) ? MAC : '1;
      if (f_typ == 8'h00) begin
        f_cnt = 16'($urandom);
        gen_pay(VW*6);
        f_flo = $urandom_range(0, VW - 1);
      end else begin
        f_cnt = {12'($urandom), 4'($urandom_range(1, AM))};
        gen_pay(2 * int'(f_cnt[3:0]));
        f_flo = $urandom_range(0, AM - 1);
      end
      f_fhi = f_flo + $urandom_range(0, 3);
      send_frame();
      check_frame($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
